// File: rtl/rrf_alloc_if.sv
// Rename-register-file allocator bus.
// Groups the dispatch requests, commit enables, flush, and the allocator
// results into one bundle.
//   master : dispatch/commit side. Drives the requests and reads the grants.
//   slave  : the allocator (rrf_alloc_ctrl).
// Handshake: a dispatch slot raises dp_reqN_i. The tag on rrftagN_o belongs to
// that slot only when alloc_enN_o is high in the same cycle, which means zero
// latency. There is no retry state inside the allocator. If stall_o is high,
// nothing is granted, and the requester holds or re-presents its request on a
// later cycle. com_en2_i only has meaning together with com_en1_i.
// state_o exposes the allocator state: 0 = RUN, 1 = RECOVER.
interface rrf_alloc_if #(
    parameter int RRF_SEL = 6
);
    logic               dp_req1_i;
    logic               dp_req2_i;
    logic               com_en1_i;
    logic               com_en2_i;
    logic               flush_i;
    logic               stall_o;
    logic [RRF_SEL-1:0] rrftag1_o;
    logic [RRF_SEL-1:0] rrftag2_o;
    logic               alloc_en1_o;
    logic               alloc_en2_o;
    logic [RRF_SEL-1:0] rrfptr_o;
    logic [RRF_SEL-1:0] comptr_o;
    logic [RRF_SEL:0]   freenum_o;
    logic               state_o;

    modport master (
        output dp_req1_i, dp_req2_i, com_en1_i, com_en2_i, flush_i,
        input  stall_o, rrftag1_o, rrftag2_o, alloc_en1_o, alloc_en2_o,
               rrfptr_o, comptr_o, freenum_o, state_o
    );

    modport slave (
        input  dp_req1_i, dp_req2_i, com_en1_i, com_en2_i, flush_i,
        output stall_o, rrftag1_o, rrftag2_o, alloc_en1_o, alloc_en2_o,
               rrfptr_o, comptr_o, freenum_o, state_o
    );
endinterface

// File: rtl/rrf_alloc_ctrl.sv
// Rename-register-file tag allocator.
// The entries form a circular FIFO. The tail pointer (rrfptr) hands out up to
// two tags per cycle. The head pointer (comptr) retires up to two tags per
// cycle. A flush discards every uncommitted tag by pulling the tail back to
// the head. After a flush, the allocator spends one RECOVER cycle in which it
// refuses all allocation.
// Ports:
//   clk_i   : clock. All state changes on the rising edge.
//   reset_i : synchronous, active-high reset.
//   bus     : rrf_alloc_if slave. Carries the requests, commits, flush,
//             tags, grants, pointers, free count and state.
module rrf_alloc_ctrl #(
    parameter int RRF_SEL = 6,
    parameter int RRF_NUM = 64
) (
    input  logic       clk_i,
    input  logic       reset_i,
    rrf_alloc_if.slave bus
);
    localparam int W = RRF_SEL;
    localparam logic [W:0] NUM_W = (W+1)'(RRF_NUM);

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t       state;
    logic [W-1:0] rrfptr;
    logic [W-1:0] comptr;
    logic [W:0]   freenum;

    logic [1:0]   reqcnt;
    logic [1:0]   grantcnt;
    logic [1:0]   comcnt_raw;
    logic [1:0]   comcnt;
    logic [W:0]   inflight;
    logic         stall;
    logic         alloc1;
    logic         alloc2;
    logic [W-1:0] comptr_nxt;

    always_comb begin
        reqcnt   = {1'b0, bus.dp_req1_i} + {1'b0, bus.dp_req2_i};
        // The free check uses the pre-commit count. Entries freed this cycle
        // only become allocatable on the next cycle.
        stall    = ({{(W-1){1'b0}}, reqcnt} > freenum)
                   || (state == RECOVER) || bus.flush_i;
        alloc1   = bus.dp_req1_i & ~stall;
        alloc2   = bus.dp_req2_i & ~stall;
        grantcnt = {1'b0, alloc1} + {1'b0, alloc2};

        // A second commit without a first one is meaningless and is dropped.
        comcnt_raw = bus.com_en1_i ? (2'd1 + {1'b0, bus.com_en2_i}) : 2'd0;
        inflight   = NUM_W - freenum;
        // Never retire more entries than are actually in flight.
        if ({{(W-1){1'b0}}, comcnt_raw} > inflight) begin
            comcnt = inflight[1:0];
        end else begin
            comcnt = comcnt_raw;
        end
        comptr_nxt = comptr + W'(comcnt);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= RUN;
            rrfptr  <= '0;
            comptr  <= '0;
            freenum <= NUM_W;
        end else begin
            comptr <= comptr_nxt;
            if (bus.flush_i) begin
                // Squash everything that has not committed. Commits in this
                // cycle still count, so the tail snaps to the new head.
                state   <= RECOVER;
                rrfptr  <= comptr_nxt;
                freenum <= NUM_W;
            end else begin
                state   <= RUN;
                rrfptr  <= rrfptr + W'(grantcnt);
                freenum <= freenum - (W+1)'(grantcnt) + (W+1)'(comcnt);
            end
        end
    end

    assign bus.stall_o     = stall;
    assign bus.alloc_en1_o = alloc1;
    assign bus.alloc_en2_o = alloc2;
    assign bus.rrftag1_o   = rrfptr;
    assign bus.rrftag2_o   = rrfptr + W'(bus.dp_req1_i);
    assign bus.rrfptr_o    = rrfptr;
    assign bus.comptr_o    = comptr;
    assign bus.freenum_o   = freenum;
    assign bus.state_o     = (state == RECOVER);
endmodule

// File: doc/rrf_alloc_ctrl.md
RRF_ALLOC_CTRL -- requirements
Module: rrf_alloc_ctrl

Interface
- REQ-001: Parameter RRF_SEL, default 6, tag width in bits.
- REQ-002: Parameter RRF_NUM, default 64 (= 2^RRF_SEL), number of rename-register entries.
- REQ-003: clk_i  in  1  single clock; all state updates on posedge.
- REQ-004: reset_i  in  1  reset, synchronous and active-high.
- REQ-005: dp_req1_i  in  1  dispatch slot 1 needs a destination tag.
- REQ-006: dp_req2_i  in  1  dispatch slot 2 needs a destination tag.
- REQ-007: com_en1_i  in  1  oldest in-flight tag retires this cycle.
- REQ-008: com_en2_i  in  1  second-oldest tag retires; valid only with com_en1_i.
- REQ-009: flush_i  in  1  squash all uncommitted allocations.
- REQ-010: stall_o  out  1  allocation refused this cycle (combinational).
- REQ-011: rrftag1_o  out  RRF_SEL  tag for slot 1.
- REQ-012: rrftag2_o  out  RRF_SEL  tag for slot 2.
- REQ-013: alloc_en1_o / alloc_en2_o  out  1 each  tag granted to slot 1/2; drives rename-table set-busy enables.
- REQ-014: rrfptr_o  out  RRF_SEL  allocation (tail) pointer.
- REQ-015: comptr_o  out  RRF_SEL  commit (head) pointer.
- REQ-016: freenum_o  out  RRF_SEL+1  free-entry count, 0..RRF_NUM.

Function
- REQ-017: Tags SHALL be allocated and freed in strict FIFO order on a circular buffer; pointer arithmetic modulo RRF_NUM, wrapping from RRF_NUM-1 to 0.
- REQ-018: reqcnt = dp_req1_i + dp_req2_i; stall_o SHALL be 1 when reqcnt > freenum_o or state is RECOVER, else 0.
- REQ-019: rrftag1_o SHALL equal rrfptr_o; rrftag2_o SHALL equal rrfptr_o + dp_req1_i (mod RRF_NUM).
- REQ-020: alloc_enN_o = dp_reqN_i AND NOT stall_o; allocation is all-or-nothing per cycle, zero latency.
- REQ-021: On allocation, rrfptr_o SHALL advance by reqcnt on the next edge.
- REQ-022: comcnt = com_en1_i ? (1 + com_en2_i) : 0; com_en2_i alone SHALL be ignored.
- REQ-023: comcnt SHALL be clipped to the in-flight count (RRF_NUM - freenum_o); commits on an empty buffer are ignored and comptr_o does not move.
- REQ-024: comptr_o SHALL advance by the clipped comcnt each edge.
- REQ-025: Next freenum_o = freenum_o - granted count + clipped comcnt; allocation checks use the pre-commit count (no same-cycle bypass of freed entries).
- REQ-026: State machine: RUN and RECOVER; RUN -> RECOVER on flush_i; RECOVER -> RUN after exactly one cycle; flush_i while in RECOVER holds RECOVER one more cycle.
- REQ-027: On flush_i, allocation in that cycle SHALL be suppressed (stall_o=1, alloc_en=0); commits in the same cycle are honoured; next rrfptr_o = next comptr_o and next freenum_o = RRF_NUM.
- REQ-028: Full (freenum_o=0): any request stalls, commits proceed. Empty (freenum_o=RRF_NUM): both slots may allocate.

Reset
- REQ-029: On reset_i at a clock edge: rrfptr_o=0, comptr_o=0, freenum_o=RRF_NUM, state=RUN; reset overrides flush, allocate and commit in the same cycle.
- REQ-030: Immediately after reset with no requests: stall_o=0, alloc_en1_o=alloc_en2_o=0, rrftag1_o=rrftag2_o=0.

Verification
- REQ-031: Reset, then dp_req1=dp_req2=1 for one cycle -> tags 0 and 1 granted; next cycle rrfptr_o=2, freenum_o=62.
- REQ-032: Only dp_req2=1 at rrfptr=5 -> rrftag2_o=5, alloc_en1_o=0; rrfptr_o becomes 6.
- REQ-033: rrfptr=63, comptr=10, freenum=11, both requests -> tags 63 and 0; rrfptr_o wraps to 1, freenum_o=9.
- REQ-034: freenum=1, both requests plus com_en1=1 -> stall_o=1, no grant; next freenum_o=2, comptr advances by 1.
- REQ-035: 20 in flight (comptr=4, rrfptr=24), flush_i with com_en1=com_en2=1 -> next comptr=rrfptr=6, freenum_o=64; stall_o=1 for the flush cycle and the one RECOVER cycle.
- REQ-036: Empty buffer (freenum=64), com_en1=com_en2=1 -> comptr_o and freenum_o unchanged.
